dvi_timing_gen: RTL and testbench
=================================

// Module: dvi_timing_gen
// PURPOSE
//  Video timing sequencer that drives the three TMDS encoder lanes for a DVI transmitter.
//  - Walks the horizontal and vertical raster and generates den, hsync and vsync.
//  - Pulls pixels from an upstream source over a valid/ready handshake.
//  - Presents per-lane {c, d, den} to the encoders, one pixel per clk.
// PARAMETERS
//  H_ACTIVE      640  visible pixels per line
//  H_FRONT       16   horizontal front porch, clks
//  H_SYNC        96   hsync width, clks
//  H_BACK        48   horizontal back porch, clks
//  V_ACTIVE      480  visible lines per frame
//  V_FRONT       10   vertical front porch, lines
//  V_SYNC        2    vsync width, lines
//  V_BACK        33   vertical back porch, lines
//  H_SYNC_POL    0    hsync active level (0 = active-low)
//  V_SYNC_POL    0    vsync active level
//  W_CTR         12   counter width; must hold H_total-1 and V_total-1
// PORTS
//  clk          in   1   pixel clock; the only clock
//  rst          in   1   asynchronous reset, active-high
//  en           in   1   raster enable
//  pix_data     in   24  {R[23:16], G[15:8], B[7:0]}
//  pix_valid    in   1   pix_data is valid
//  pix_ready    out  1   block consumes pix_data this clk (combinational)
//  den          out  1   data enable, common to all lanes
//  c0           out  2   lane 0 control, {vsync, hsync}
//  c1, c2       out  2   lane 1/2 control, tied 2'b00
//  d0, d1, d2   out  8   lane data: d0=B, d1=G, d2=R
//  line_start   out  1   1-clk pulse, first active pixel of each line
//  frame_start  out  1   1-clk pulse, first active pixel of line 0
//  underflow    out  1   sticky: a pixel was needed but not valid
//  underflow_clr in  1   clears underflow
// BEHAVIOUR
//  Raster counters
//  - hctr counts 0..H_total-1, where H_total = sum of the H_* parameters.
//  - Horizontal regions in order: ACTIVE [0,H_ACTIVE), FRONT, SYNC, BACK.
//  - vctr increments when hctr wraps; it counts 0..V_total-1.
//  - Vertical regions in the same order: ACTIVE, FRONT, SYNC, BACK.
//  - Each region is decoded by compare against the current counter value.
//    No region may have zero length; zero lengths are unsupported.
//  Handshake
//  - pix_ready = en & hACTIVE & vACTIVE, decoded from the current counters.
//  - A transfer happens on any clk with pix_valid & pix_ready.
//  - When pix_ready=0, pix_valid is ignored and data is never consumed.
//  Output timing
//  - All outputs except pix_ready are registered: 1 clk after the counter state that produced them.
//  - den: registered pix_ready.
//  - d0/d1/d2: registered pix_data when pix_valid.
//    If pix_ready & !pix_valid, d* = 0 (black) and underflow is set next clk.
//    When den=0, d* hold 0.
//  - hsync = H_SYNC_POL when hctr is in the SYNC region, else ~H_SYNC_POL.
//  - vsync = V_SYNC_POL when vctr is in the SYNC region, else ~V_SYNC_POL.
//    vsync changes only at hctr==0 boundaries.
//  - Syncs are valid during den too; the encoder ignores c while den=1.
//  Strobes and flags
//  - line_start = registered (pix_ready & hctr==0).
//  - frame_start additionally requires vctr==0.
//  - underflow: set wins over a simultaneous underflow_clr.
//  Enable
//  - en=0: hctr and vctr load 0 at the next edge and hold there.
//    Registered outputs become den=0, d*=0, syncs inactive.
//  - en rising: hctr=0, vctr=0 on the first enabled clk.
//    The frame starts with a full line 0; no partial frame is emitted.
//  - en may fall mid-line; the current line is abandoned without completing sync.
//  Reset
//  - Asynchronous assert: hctr=vctr=0; den=0; d*=0; c0={~V_SYNC_POL, ~H_SYNC_POL}.
//    Also line_start=frame_start=underflow=0.
//  - Reset mid-frame behaves identically; after release the block acts as on an en rising edge.
//  Widths
//  - Counter compares are unsigned W_CTR-bit.
//  - Parameter sums that exceed 2^W_CTR are a configuration error; check with an elaboration assertion.
// TESTING
//  1. Defaults, en=1, pix_valid=1 held:
//     - den high for 640 consecutive clks per line; line period 800 clks.
//     - hsync low for clks 656..751 of the line (relative to den rise).
//     - 480 den lines per frame; frame period 420000 clks.
//  2. vsync: low for exactly 2 lines (1600 clks), starting 490 lines after frame_start.
//     frame_start pulses once per 420000 clks; line_start pulses 480 times per frame.
//  3. Data path: ramp pix_data = 24'hRRGGBB incrementing on each transfer.
//     - d2/d1/d0 match the ramp 1 clk later, in the den cycle.
//     - No pixel is skipped or duplicated across 2 frames.
//  4. Underflow: drop pix_valid for pixel 100 of line 5.
//     - That den cycle shows d*=0; underflow=1 on the next clk and stays 1.
//     - Pulse underflow_clr -> 0.
//     - Assert underflow_clr in the same clk as a new underflow event -> flag stays 1.
//  5. Polarity and small raster: H_SYNC_POL=V_SYNC_POL=1, raster 4/1/2/1 x 3/1/1/1.
//     - hsync high exactly 2 clks per 8-clk line; vsync high 1 line of 6.
//     - den pattern matches the hand-computed table.
//  6. en low at hctr=300, vctr=200 for 10 clks, then high:
//     - den=0 and syncs inactive during the gap.
//     - The first den after re-enable coincides with frame_start.
//     - Asserting rst mid-line gives identical results.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// Raster timing sequencer feeding three TMDS encoder lanes: den/hsync/vsync plus pixel data.
// Latency: 1 clk from counter state to all outputs except the combinational pix_ready.
// Backpressure: pix_ready is high only in active video; a missing pixel shows as black and sets underflow.
module dvi_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int W_CTR      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        den,
    output logic [1:0]  c0,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic [7:0]  d0,
    output logic [7:0]  d1,
    output logic [7:0]  d2,
    output logic        line_start,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (1 << W_CTR) || V_TOTAL > (1 << W_CTR)) begin : g_width_err
        $error("dvi_timing_gen: raster totals do not fit in W_CTR bits");
    end
    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_len_err
        $error("dvi_timing_gen: zero-length raster region");
    end

    localparam logic [W_CTR-1:0] H_ACT_END  = W_CTR'(H_ACTIVE);
    localparam logic [W_CTR-1:0] H_SYNC_BEG = W_CTR'(H_ACTIVE + H_FRONT);
    localparam logic [W_CTR-1:0] H_SYNC_END = W_CTR'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [W_CTR-1:0] H_LAST     = W_CTR'(H_TOTAL - 1);
    localparam logic [W_CTR-1:0] V_ACT_END  = W_CTR'(V_ACTIVE);
    localparam logic [W_CTR-1:0] V_SYNC_BEG = W_CTR'(V_ACTIVE + V_FRONT);
    localparam logic [W_CTR-1:0] V_SYNC_END = W_CTR'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [W_CTR-1:0] V_LAST     = W_CTR'(V_TOTAL - 1);
    localparam logic [W_CTR-1:0] CTR_ONE    = W_CTR'(1);

    logic [W_CTR-1:0] hctr;
    logic [W_CTR-1:0] vctr;
    logic             h_act;
    logic             v_act;
    logic             h_sync;
    logic             v_sync;
    logic             h_zero;
    logic             v_zero;
    logic             hsync_q;
    logic             vsync_q;
    logic [23:0]      pix_q;

    assign h_act  = hctr < H_ACT_END;
    assign v_act  = vctr < V_ACT_END;
    assign h_sync = (hctr >= H_SYNC_BEG) && (hctr < H_SYNC_END);
    assign v_sync = (vctr >= V_SYNC_BEG) && (vctr < V_SYNC_END);
    assign h_zero = hctr == '0;
    assign v_zero = vctr == '0;

    assign pix_ready = en & h_act & v_act;

    // Counters park at 0 while disabled so re-enable always starts a full frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hctr <= '0;
            vctr <= '0;
        end else if (!en) begin
            hctr <= '0;
            vctr <= '0;
        end else if (hctr == H_LAST) begin
            hctr <= '0;
            vctr <= (vctr == V_LAST) ? '0 : vctr + CTR_ONE;
        end else begin
            hctr <= hctr + CTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            den         <= 1'b0;
            pix_q       <= '0;
            hsync_q     <= ~H_SYNC_POL;
            vsync_q     <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            den         <= pix_ready;
            pix_q       <= (pix_ready && pix_valid) ? pix_data : 24'h0;
            hsync_q     <= (en && h_sync) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q     <= (en && v_sync) ? V_SYNC_POL : ~V_SYNC_POL;
            line_start  <= pix_ready & h_zero;
            frame_start <= pix_ready & h_zero & v_zero;
            // A new starved pixel outranks a clear in the same clk.
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign c0 = {vsync_q, hsync_q};
    assign c1 = 2'b00;
    assign c2 = 2'b00;
    assign d2 = pix_q[23:16];
    assign d1 = pix_q[15:8];
    assign d0 = pix_q[7:0];

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Drives a shrunken raster with random valid/enable traffic and checks every clk against a
// position-based model (cycles since enable, split into line/pixel by division).
module tb_dvi_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        den;
    logic [1:0]  c0, c1, c2;
    logic [7:0]  d0, d1, d2;
    logic        line_start;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;

    int n_cmp = 0;
    int n_mis = 0;
    int pos   = 0;
    bit exp_uf = 1'b0;

    always #5 clk = ~clk;

    dvi_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .W_CTR(5)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .den(den), .c0(c0), .c1(c1), .c2(c2),
        .d0(d0), .d1(d1), .d2(d2),
        .line_start(line_start), .frame_start(frame_start),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, got, exp, pos);
        end
    endtask

    task automatic chk_reset();
        chk("rst_den", {31'b0, den}, 32'd0);
        chk("rst_d", {8'b0, d2, d1, d0}, 32'd0);
        chk("rst_c0", {30'b0, c0}, {30'b0, !VPOL, !HPOL});
        chk("rst_ls", {31'b0, line_start}, 32'd0);
        chk("rst_fs", {31'b0, frame_start}, 32'd0);
        chk("rst_uf", {31'b0, underflow}, 32'd0);
    endtask

    // One pixel clock: drive inputs, predict from raster position, compare after the edge.
    task automatic step(input bit e, input bit v, input bit clr);
        int h, ln;
        bit act, hs, vs;
        logic [23:0] dexp;
        en = e;
        pix_valid = v;
        underflow_clr = clr;
        pix_data = 24'($urandom);
        h  = pos % HT;
        ln = (pos / HT) % VT;
        act = e && h < HA && ln < VA;
        hs  = e && h >= HA + HF && h < HA + HF + HS;
        vs  = e && ln >= VA + VF && ln < VA + VF + VS;
        #1;
        chk("pix_ready", {31'b0, pix_ready}, {31'b0, act});
        dexp = (act && v) ? pix_data : 24'h0;
        if (act && !v) exp_uf = 1'b1;
        else if (clr) exp_uf = 1'b0;
        @(posedge clk);
        #1;
        pos = e ? pos + 1 : 0;
        chk("den", {31'b0, den}, {31'b0, act});
        chk("d", {8'b0, d2, d1, d0}, {8'b0, dexp});
        chk("c0", {30'b0, c0}, {30'b0, (vs ? VPOL : !VPOL), (hs ? HPOL : !HPOL)});
        chk("c12", {28'b0, c1, c2}, 32'd0);
        chk("line_start", {31'b0, line_start}, {31'b0, act && h == 0});
        chk("frame_start", {31'b0, frame_start}, {31'b0, act && h == 0 && ln == 0});
        chk("underflow", {31'b0, underflow}, {31'b0, exp_uf});
    endtask

    task automatic goto(input int h, input int ln);
        for (int i = 0; i <= HT * VT && !((pos % HT) == h && ((pos / HT) % VT) == ln); i++)
            step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pix_valid = 1'b0; underflow_clr = 1'b0; pix_data = '0;
        #2;
        chk_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // Three frames of mostly-valid traffic with occasional starvation and clears.
        for (int i = 0; i < 3 * HT * VT; i++)
            step(1'b1, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0);

        // Underflow: set, hold, clear, then set and clear in the same clk.
        goto(5, 2);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("uf_set", {31'b0, underflow}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("uf_sticky", {31'b0, underflow}, 32'd1);
        step(1'b1, 1'b1, 1'b1);
        chk("uf_clr", {31'b0, underflow}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("uf_set_wins", {31'b0, underflow}, 32'd1);

        // Mid-line enable gap: the next den must be a frame start.
        goto(10, 4);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("fs_reenable", {31'b0, frame_start}, 32'd1);
        for (int i = 0; i < HT * VT + 5; i++) step(1'b1, 1'b1, 1'b0);

        // Random enable drops.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);

        // Reset mid-line behaves like an enable restart.
        goto(10, 4);
        rst = 1'b1;
        #1;
        chk_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        pos = 0;
        exp_uf = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("fs_after_rst", {31'b0, frame_start}, 32'd1);
        for (int i = 0; i < HT * VT; i++)
            step(1'b1, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
